// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage of the 16-bit multi-cycle CPU:
// instruction width, reset PC default and the fetch FSM state codes.
package instr_fetch_pkg;

    // Width of one instruction word as delivered by memory port A.
    localparam int INSTR_W = 16;

    // Default word-address width of the PC and memory port A.
    localparam int ADDR_W_DEF = 16;

    // Default PC loaded on reset.
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;

    // Fetch FSM state codes; the fourth encoding is illegal and recovers to ISSUE.
    typedef enum logic [1:0] {
        FS_ISSUE = 2'b00,  // ready to issue a read on port A
        FS_WAIT  = 2'b01,  // read in flight, data arrives this cycle
        FS_HOLD  = 2'b10   // instruction register holds a live instruction
    } fetch_state_e;

    // Next sequential word address, wrapping modulo 2^16.
    function automatic logic [15:0] pc_next16(input logic [15:0] pc);
        return pc + 16'd1;
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads instruction words over memory
// port A (1-cycle synchronous RAM), latches them into the instruction register
// and offers them to decode through a valid/ready handshake. Branch/jump
// redirects and port A arbitration (mem_busy) are handled here.
//
// Handshake: an instruction transfers on a rising edge where
// instr_valid==1 and instr_ready==1. While instr_valid==1 and instr_ready==0,
// instr and instr_pc are held stable. br_taken discards any live or in-flight
// instruction regardless of instr_ready.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,        // synchronous, active low
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               fetch_req,
    input  logic               mem_busy,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    output logic [1:0]         dbg_state     // current fetch FSM state code
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               fetch_req_c;

    // Next-state, next-register values and fetch request; redirect has top priority.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_pc_d  = instr_pc_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        fetch_req_c = 1'b0;

        if (br_taken) begin
            // Any in-flight read is dropped: the WAIT capture is skipped.
            state_d = FS_ISSUE;
            pc_d    = br_target;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                FS_ISSUE: begin
                    if (!mem_busy) begin
                        fetch_req_c = 1'b1;
                        state_d     = FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    // The RAM already holds the address, so mem_busy is ignored here.
                    instr_d    = mem_rdata;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    pc_d       = pc_q + PC_ONE;
                    state_d    = FS_HOLD;
                end
                FS_HOLD: begin
                    if (instr_ready) begin
                        valid_d = 1'b0;
                        if (!mem_busy) begin
                            // Back-to-back fetch while handing the instruction over.
                            fetch_req_c = 1'b1;
                            state_d     = FS_WAIT;
                        end else begin
                            state_d = FS_ISSUE;
                        end
                    end
                end
                default: begin
                    state_d = FS_ISSUE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // State, PC and instruction register update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= FS_ISSUE;
            pc_q       <= RESET_PC;
            instr_pc_q <= RESET_PC;
            instr_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_pc_q <= instr_pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
        end
    end

    assign mem_addr    = pc_q;
    assign fetch_req   = fetch_req_c;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign dbg_state   = state_q;

endmodule
